// File: rtl/ccc_seq_pkg.sv
// rtl/ccc_seq_pkg.sv - shared state type, stage indices and helpers for the CCC lock sequencer
package ccc_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam int STG_BUS    = 0;
  localparam int STG_PERIPH = 1;
  localparam int STG_APP    = 2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ccc_lock_sequencer_if.sv
// rtl/ccc_lock_sequencer_if.sv - lock input and reset/status outputs of the sequencer
// Optional LOSS_CLR/LOSS_IRQ pair is present only with CCC_SEQ_LOSS_IRQ_EN defined.
interface ccc_lock_sequencer_if;
  logic       LOCK_IN;
  logic [2:0] RST_OUT;
  logic       READY;
  logic [7:0] LOSS_CNT;
  logic [1:0] STATE;
`ifdef CCC_SEQ_LOSS_IRQ_EN
  logic       LOSS_CLR;
  logic       LOSS_IRQ;
`endif

  modport master (
    input  LOCK_IN,
    output RST_OUT,
    output READY,
    output LOSS_CNT,
    output STATE
`ifdef CCC_SEQ_LOSS_IRQ_EN
    ,
    input  LOSS_CLR,
    output LOSS_IRQ
`endif
  );

  modport slave (
    output LOCK_IN,
    input  RST_OUT,
    input  READY,
    input  LOSS_CNT,
    input  STATE
`ifdef CCC_SEQ_LOSS_IRQ_EN
    ,
    output LOSS_CLR,
    input  LOSS_IRQ
`endif
  );
endinterface

// File: rtl/lock_sync.sv
// rtl/lock_sync.sv - two-flop synchronizer bringing the asynchronous CCC lock into PCLK
module lock_sync (
  input  logic PCLK,
  input  logic PRESET,
  input  logic i_async,
  output logic o_sync
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;
endmodule

// File: rtl/ccc_lock_sequencer.sv
// rtl/ccc_lock_sequencer.sv - filters CCC lock, then releases staged resets bus->periph->app
// Loss interrupt (LOSS_CLR/LOSS_IRQ) is built only when CCC_SEQ_LOSS_IRQ_EN is defined.
module ccc_lock_sequencer
  import ccc_seq_pkg::*;
#(
  parameter int LOCK_FILTER = 256,
  parameter int STAGE_GAP   = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  ccc_lock_sequencer_if.master  seq_if
);
  localparam int FW = $clog2(LOCK_FILTER);
  localparam int GW = $clog2(2 * STAGE_GAP);
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [GW-1:0] GAP_MID   = GW'(STAGE_GAP);
  localparam logic [GW-1:0] GAP_LAST  = GW'(2 * STAGE_GAP - 1);

  seq_state_e    r_state, w_state_nxt;
  logic [FW-1:0] r_fcnt, w_fcnt_nxt;
  logic [GW-1:0] r_gcnt, w_gcnt_nxt;
  logic [2:0]    r_rst, w_rst_nxt;
  logic          r_ready, w_ready_nxt;
  logic [7:0]    r_loss, w_loss_nxt;
  logic          w_loss_evt;
  logic          w_lock_s;

  lock_sync u_lock_sync (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .i_async (seq_if.LOCK_IN),
    .o_sync  (w_lock_s)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= WAIT_LOCK;
      r_fcnt  <= '0;
      r_gcnt  <= '0;
      r_rst   <= 3'b111;
      r_ready <= 1'b0;
      r_loss  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_gcnt  <= w_gcnt_nxt;
      r_rst   <= w_rst_nxt;
      r_ready <= w_ready_nxt;
      r_loss  <= w_loss_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = '0;
    w_gcnt_nxt  = '0;
    w_loss_evt  = 1'b0;
    case (r_state)
      WAIT_LOCK: if (w_lock_s) w_state_nxt = FILTER;
      FILTER: begin
        if (!w_lock_s)               w_state_nxt = WAIT_LOCK;
        else if (r_fcnt == FILT_LAST) w_state_nxt = RELEASE;
        else                          w_fcnt_nxt  = r_fcnt + FW'(1);
      end
      RELEASE: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_loss_evt  = 1'b1;
        end else if (r_gcnt == GAP_LAST) begin
          w_state_nxt = RUN;
        end else begin
          w_gcnt_nxt = r_gcnt + GW'(1);
        end
      end
      RUN: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_loss_evt  = 1'b1;
        end
      end
      default: w_state_nxt = WAIT_LOCK;
    endcase

    // Outputs are decoded from the next state so each register matches its state cycle.
    w_rst_nxt = 3'b111;
    case (w_state_nxt)
      RELEASE: begin
        w_rst_nxt[STG_BUS]    = 1'b0;
        w_rst_nxt[STG_PERIPH] = (w_gcnt_nxt < GAP_MID);
        w_rst_nxt[STG_APP]    = 1'b1;
      end
      RUN:     w_rst_nxt = 3'b000;
      default: w_rst_nxt = 3'b111;
    endcase
    w_ready_nxt = (w_state_nxt == RUN);
    w_loss_nxt  = w_loss_evt ? sat_inc8(r_loss) : r_loss;
  end

  assign seq_if.RST_OUT  = r_rst;
  assign seq_if.READY    = r_ready;
  assign seq_if.LOSS_CNT = r_loss;
  assign seq_if.STATE    = r_state;

`ifdef CCC_SEQ_LOSS_IRQ_EN
  logic r_irq;

  // A loss in the same cycle as a clear wins, so no event is ever dropped.
  always_ff @(posedge PCLK) begin
    if (PRESET)               r_irq <= 1'b0;
    else if (w_loss_evt)      r_irq <= 1'b1;
    else if (seq_if.LOSS_CLR) r_irq <= 1'b0;
  end

  assign seq_if.LOSS_IRQ = r_irq;
`endif
endmodule
